// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, stall/redirect handling
// and a saturating load-use stall counter; one-cycle latency from fetch to ID.
module if_id_stage #(
  parameter int          DELAY_SLOT = 1,
  parameter logic [31:0] NOP        = 32'h00000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        stall_in,
  input  logic        idex_memRead,
  input  logic [4:0]  idex_rt,
  input  logic        redirect,
  output logic        PCWrite,
  output logic        bubble,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic [15:0] stall_count
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic        rs_match;
  logic        rt_match;
  logic        hz;

  // A squashed slot (valid=0) or a load into $0 can never create a dependency.
  always_comb begin
    rs_match = (idex_rt == ifid_instr_q[25:21]);
    rt_match = (idex_rt == ifid_instr_q[20:16]);
    hz       = (state_q == RUN) && idex_memRead && (idex_rt != 5'd0) &&
               ifid_valid_q && (rs_match || rt_match);
  end

  always_comb begin
    state_d       = state_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_valid_d  = ifid_valid_q;
    stall_count_d = stall_count_q;
    PCWrite       = 1'b1;
    bubble        = 1'b0;

    if (Reset) begin
      PCWrite = 1'b1;
      bubble  = 1'b0;
    end else if (stall_in) begin
      PCWrite = 1'b0;
    end else if (hz) begin
      // Redirect is dropped here; the branch stays in ID and resolves again after the bubble.
      PCWrite = 1'b0;
      bubble  = 1'b1;
      state_d = STALL;
      if (stall_count_q != 16'hFFFF) begin
        stall_count_d = stall_count_q + 16'd1;
      end
    end else if (redirect && (DELAY_SLOT == 0)) begin
      state_d      = RUN;
      ifid_pc_d    = pc_in + 32'd4;
      ifid_instr_d = NOP;
      ifid_valid_d = 1'b0;
    end else begin
      state_d      = RUN;
      ifid_pc_d    = pc_in + 32'd4;
      ifid_instr_d = instr_in;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= RUN;
      ifid_pc_q     <= 32'd0;
      ifid_instr_q  <= NOP;
      ifid_valid_q  <= 1'b0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_valid_q  <= ifid_valid_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_valid  = ifid_valid_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: delay-slot (DELAY_SLOT=1) and squashing (DELAY_SLOT=0) instances share stimulus.
module tb_if_id_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] pc_in;
  logic [31:0] instr_in;
  logic        stall_in;
  logic        idex_memRead;
  logic [4:0]  idex_rt;
  logic        redirect;

  logic        pcw1, bub1, vld1;
  logic [31:0] pc1, ins1;
  logic [15:0] cnt1;
  logic        pcw0, bub0, vld0;
  logic [31:0] pc0, ins0;
  logic [15:0] cnt0;

  int passed = 0;
  int total  = 0;

  localparam logic [31:0] LW_USE = 32'h00A22821;  // addu $5,$5,$2 : rs=5, rt=2
  localparam logic [31:0] RD_ZERO = 32'h00001020; // add $2,$0,$0

  always #5 Clk = ~Clk;

  if_id_stage #(.DELAY_SLOT(1), .NOP(32'h00000000)) dut (
    .Clk(Clk), .Reset(Reset), .pc_in(pc_in), .instr_in(instr_in), .stall_in(stall_in),
    .idex_memRead(idex_memRead), .idex_rt(idex_rt), .redirect(redirect),
    .PCWrite(pcw1), .bubble(bub1), .ifid_pc(pc1), .ifid_instr(ins1),
    .ifid_valid(vld1), .stall_count(cnt1)
  );

  if_id_stage #(.DELAY_SLOT(0), .NOP(32'h00000000)) dut_sq (
    .Clk(Clk), .Reset(Reset), .pc_in(pc_in), .instr_in(instr_in), .stall_in(stall_in),
    .idex_memRead(idex_memRead), .idex_rt(idex_rt), .redirect(redirect),
    .PCWrite(pcw0), .bubble(bub0), .ifid_pc(pc0), .ifid_instr(ins0),
    .ifid_valid(vld0), .stall_count(cnt0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
    pc_in    = pc;
    instr_in = ins;
    #1;
  endtask

  initial begin
    Reset = 1'b1; pc_in = 32'h0; instr_in = 32'h0; stall_in = 1'b0;
    idex_memRead = 1'b0; idex_rt = 5'd0; redirect = 1'b0;
    #1;
    chk("rst_pcwrite", {31'd0, pcw1}, 32'd1);
    chk("rst_bubble", {31'd0, bub1}, 32'd0);
    tick();
    chk("rst_pc", pc1, 32'd0);
    chk("rst_instr", ins1, 32'd0);
    chk("rst_valid", {31'd0, vld1}, 32'd0);
    chk("rst_count", {16'd0, cnt1}, 32'd0);
    Reset = 1'b0;

    // Straight-line fetch
    for (int i = 0; i < 3; i++) begin
      fetch(32'(i * 4), 32'h1000_0000 + 32'(i));
      chk("seq_pcwrite", {31'd0, pcw1}, 32'd1);
      tick();
      chk("seq_pc", pc1, 32'(i * 4 + 4));
      chk("seq_instr", ins1, 32'h1000_0000 + 32'(i));
      chk("seq_valid", {31'd0, vld1}, 32'd1);
    end

    // Load into $0 never stalls
    fetch(32'h20, RD_ZERO);
    tick();
    idex_memRead = 1'b1; idex_rt = 5'd0;
    fetch(32'h24, 32'h2000_0000);
    chk("z_pcwrite", {31'd0, pcw1}, 32'd1);
    chk("z_bubble", {31'd0, bub1}, 32'd0);
    tick();
    chk("z_count", {16'd0, cnt1}, 32'd0);
    chk("z_pc", pc1, 32'h28);
    idex_memRead = 1'b0;

    // Load-use stall
    fetch(32'h10, LW_USE);
    tick();
    idex_memRead = 1'b1; idex_rt = 5'd5;
    fetch(32'h14, 32'h3000_0001);
    chk("lu_pcwrite", {31'd0, pcw1}, 32'd0);
    chk("lu_bubble", {31'd0, bub1}, 32'd1);
    tick();
    chk("lu_hold_pc", pc1, 32'h14);
    chk("lu_hold_instr", ins1, LW_USE);
    chk("lu_count", {16'd0, cnt1}, 32'd1);
    // STALL state ignores the still-matching load
    chk("lu_stall_pcwrite", {31'd0, pcw1}, 32'd1);
    chk("lu_stall_bubble", {31'd0, bub1}, 32'd0);
    tick();
    chk("lu_adv_pc", pc1, 32'h18);
    chk("lu_adv_instr", ins1, 32'h3000_0001);
    idex_memRead = 1'b0;

    // Redirect: delay slot kept vs squashed
    redirect = 1'b1;
    fetch(32'h30, 32'h2222_2222);
    chk("rd_pcwrite", {31'd0, pcw0}, 32'd1);
    tick();
    chk("rd_ds1_instr", ins1, 32'h2222_2222);
    chk("rd_ds1_valid", {31'd0, vld1}, 32'd1);
    chk("rd_ds0_instr", ins0, 32'd0);
    chk("rd_ds0_valid", {31'd0, vld0}, 32'd0);
    chk("rd_ds0_pc", pc0, 32'h34);
    redirect = 1'b0;

    // Redirect coincident with hazard is ignored
    fetch(32'h40, LW_USE);
    tick();
    idex_memRead = 1'b1; idex_rt = 5'd5; redirect = 1'b1;
    fetch(32'h44, 32'h3333_3333);
    chk("rh_ds0_bubble", {31'd0, bub0}, 32'd1);
    tick();
    chk("rh_ds0_instr", ins0, LW_USE);
    chk("rh_ds0_valid", {31'd0, vld0}, 32'd1);
    chk("rh_count", {16'd0, cnt1}, 32'd2);

    // stall_in freezes the STALL state for 3 cycles
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("si_pcwrite", {31'd0, pcw1}, 32'd0);
      chk("si_bubble", {31'd0, bub1}, 32'd0);
      tick();
      chk("si_pc", pc1, 32'h44);
      chk("si_instr", ins1, LW_USE);
    end
    stall_in = 1'b0;
    #1;
    chk("si_resume_pcwrite", {31'd0, pcw1}, 32'd1);
    chk("si_resume_bubble", {31'd0, bub1}, 32'd0);
    tick();
    chk("si_resume_ds1", ins1, 32'h3333_3333);
    chk("si_resume_ds0", {31'd0, vld0}, 32'd0);
    redirect = 1'b0;
    #1;
    chk("si_run_pcwrite", {31'd0, pcw1}, 32'd1);

    // Saturation, then reset in STALL
    fetch(32'h50, LW_USE);
    tick();
    force dut.stall_count_q = 16'hFFFE;
    #1;
    release dut.stall_count_q;
    #1;
    chk("sat_bubble", {31'd0, bub1}, 32'd1);
    tick();
    chk("sat_ffff", {16'd0, cnt1}, 32'h0000FFFF);
    tick();
    chk("sat_again_bubble", {31'd0, bub1}, 32'd1);
    tick();
    chk("sat_hold", {16'd0, cnt1}, 32'h0000FFFF);
    Reset = 1'b1;
    #1;
    chk("rs_pcwrite", {31'd0, pcw1}, 32'd1);
    chk("rs_bubble", {31'd0, bub1}, 32'd0);
    tick();
    chk("rs_pc", pc1, 32'd0);
    chk("rs_instr", ins1, 32'd0);
    chk("rs_valid", {31'd0, vld1}, 32'd0);
    chk("rs_count", {16'd0, cnt1}, 32'd0);
    Reset = 1'b0;
    #1;
    chk("rs_invalid_no_hz", {31'd0, bub1}, 32'd0);
    tick();
    // Back in RUN: the freshly latched dependent instruction must stall
    #1;
    chk("rs_run_bubble", {31'd0, bub1}, 32'd1);
    idex_memRead = 1'b0;

    // PC+4 wraps
    fetch(32'hFFFF_FFFC, 32'h4444_4444);
    tick();
    chk("wrap_pc", pc1, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter DELAY_SLOT, default 1: 1 keeps the instruction fetched behind a taken branch or jump (MIPS delay slot); 0 squashes it.
REQ-002 Parameter NOP, default 32'h00000000: instruction word latched when the stage is squashed.
REQ-003 Clk  in  1  single clock; all state changes on posedge Clk.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 pc_in  in  32  current PC (PCResult from the program counter).
REQ-006 instr_in  in  32  instruction word from instruction memory for pc_in.
REQ-007 stall_in  in  1  external freeze request (e.g. memory wait).
REQ-008 idex_memRead  in  1  ID/EX holds a load.
REQ-009 idex_rt  in  5  destination register of the load in ID/EX.
REQ-010 redirect  in  1  taken branch or jump resolved in ID this cycle.
REQ-011 PCWrite  out  1  PC update enable, driven to the program counter.
REQ-012 bubble  out  1  forces the control unit to no-op (drives its reset input).
REQ-013 ifid_pc  out  32  registered pc_in+4.
REQ-014 ifid_instr  out  32  registered instruction.
REQ-015 ifid_valid  out  1  ifid_instr is a real, non-squashed instruction.
REQ-016 stall_count  out  16  saturating count of load-use stall cycles.

Function
REQ-017 State machine has two states, RUN and STALL; the reset state is RUN.
REQ-018 Load-use hazard (hz) = state RUN & idex_memRead & idex_rt != 0 & ifid_valid & (idex_rt == ifid_instr[25:21] | idex_rt == ifid_instr[20:16]); evaluated combinationally.
REQ-019 Per-cycle priority: Reset > stall_in > hz > redirect > normal advance.
REQ-020 stall_in=1: PCWrite=0, bubble=0, all registers and the state hold.
REQ-021 hz=1 (stall_in=0): PCWrite=0, bubble=1, IF/ID registers hold, state goes to STALL, stall_count increments (saturates at 16'hFFFF).
REQ-022 STALL state lasts exactly one cycle (unless stall_in holds it): no hazard detection, PCWrite=1, bubble=0, normal advance, next state RUN.
REQ-023 Normal advance: PCWrite=1, bubble=0, ifid_pc<=pc_in+4 (modulo 2^32), ifid_instr<=instr_in, ifid_valid<=1.
REQ-024 redirect=1 with DELAY_SLOT=1: identical to normal advance.
REQ-025 redirect=1 with DELAY_SLOT=0: PCWrite=1, ifid_instr<=NOP, ifid_valid<=0, ifid_pc<=pc_in+4.
REQ-026 redirect coincident with hz: redirect is ignored that cycle; the branch in ID is re-evaluated after the stall.
REQ-027 ifid_valid=0 suppresses hazard detection (a squashed slot never stalls).
REQ-028 pc_in=32'hFFFFFFFC: ifid_pc wraps to 32'h00000000.
REQ-029 Latency: an instruction presented at cycle n appears on ifid_instr after posedge n+1 absent stalls.

Reset
REQ-030 Reset=1 at a posedge: ifid_pc=0, ifid_instr=NOP, ifid_valid=0, stall_count=0, state=RUN; this takes priority over every other input, including mid-stall.
REQ-031 While Reset=1: PCWrite=1, bubble=0.

Verification
REQ-032 Straight-line fetch: pc_in 0,4,8 with distinct instr_in -> ifid_pc 4,8,12 one cycle later, ifid_valid=1, PCWrite constantly 1.
REQ-033 Load-use: ifid_instr=32'h00A22821 (rs=5), idex_memRead=1, idex_rt=5 -> one cycle PCWrite=0, bubble=1, IF/ID held, stall_count=1; next cycle advances with PCWrite=1.
REQ-034 Hazard to $0: idex_memRead=1, idex_rt=0, instruction reading $0 -> no stall, stall_count stays 0.
REQ-035 Redirect: DELAY_SLOT=1 -> slot instruction latched with valid=1; DELAY_SLOT=0 -> ifid_instr=0, ifid_valid=0; a concurrent hazard suppresses the redirect.
REQ-036 stall_in held 3 cycles during STALL -> all outputs frozen, PCWrite=0, bubble=0; resumes in STALL, then RUN.
REQ-037 Reset asserted in STALL with stall_count=16'hFFFF -> next cycle state RUN, all outputs at reset values; saturation checked beforehand (an extra hazard leaves the count at 16'hFFFF).
